mandelbrot_dispatch: RTL and testbench
======================================

Name: mandelbrot_dispatch

Overview:
Frame-level scheduler that shares one raster scan among NUM_CORES Mandelbrot iteration cores. It walks pixels in raster order and computes each pixel's complex coordinate incrementally. It issues each pixel to a free core in strict round-robin order and retires results in the same order, so the pixel packer receives a raster-ordered RGB stream. It sits between the AXI-Lite register file (frame configuration) and the packer.

Parameters:
NUM_CORES, 4, number of iteration cores (1..16)
X_SIZE, 1024, pixels per line
Y_SIZE, 768, lines per frame

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous active-high reset
start  in  1  pulse; begin a frame
zoom_f  in  32  pixel step, signed fixed point
re_lower  in  32  real coordinate of x=0
im_upper  in  32  imaginary coordinate of y=0
busy  out  1  high from LOAD through DRAIN
frame_done  out  1  one-cycle pulse after last pixel retired
core_start  out  NUM_CORES  one-hot issue pulse
core_c_re  out  32  real coordinate, shared bus, valid with core_start
core_c_im  out  32  imaginary coordinate, shared bus
core_ready  in  NUM_CORES  core idle and holding no result
core_done  in  NUM_CORES  result held valid until acked
core_rgb  in  24*NUM_CORES  result of core k at [24k+:24]
core_ack  out  NUM_CORES  one-hot pulse; result consumed
out_rgb  out  24  pixel to packer
out_valid  out  1  out_* valid
out_ready  in  1  packer accepts
out_sof  out  1  pixel (0,0)
out_eol  out  1  x == X_SIZE-1

Behaviour:
- Reset: all outputs 0, state IDLE, issue_ptr = retire_ptr = 0, all counters 0. Reset mid-frame aborts the frame with no frame_done. Cores share areset.
- States: IDLE -> LOAD on start; LOAD -> RUN after 1 cycle; RUN -> DRAIN on the cycle the last pixel issues; DRAIN -> IDLE when the last pixel is accepted by the output stage, with frame_done pulsing that cycle. start is ignored outside IDLE.
- LOAD: copy zoom_f, re_lower and im_upper into shadow registers. Set issue x=y=0, c_re=re_lower, c_im=im_upper. Input changes after LOAD do not affect the current frame.
- Issue (RUN): when core_ready[issue_ptr] is high, assert core_start[issue_ptr] for one cycle with the current c_re/c_im. Then:
  - x++, c_re += zoom;
  - at x==X_SIZE-1: x=0, c_re=re_lower, y++, c_im -= zoom;
  - issue_ptr = (issue_ptr+1) mod NUM_CORES.
  - If core_ready[issue_ptr] is low, stall. Never skip to another core.
- Arithmetic: 32-bit two's complement, wraps modulo 2^32. The coordinate for pixel (x,y) must equal re_lower + x*zoom_f and im_upper - y*zoom_f.
- Retire (RUN/DRAIN): a single output register loads when core_done[retire_ptr] is high and (!out_valid || out_ready).
  - Same cycle: core_ack[retire_ptr]=1, retire_ptr advances, retire x/y advance.
  - Latency: 1 cycle from core_done to out_valid.
  - out_sof/out_eol are derived from retire x/y.
  - Holding: out_* stay stable while out_valid && !out_ready.
  - Full throughput: 1 pixel/cycle when cores are done and out_ready is high.
- Out-of-order completion: done from cores other than retire_ptr is held by the core and never acked early.
- Simultaneous events:
  - Issue and retire in the same cycle to different cores is allowed.
  - The same core cannot be both, because core_ready is low while done is pending.
- NUM_CORES=1: degenerates to strictly serial issue/retire.

Optional Feature:
DISPATCH_PERF_EN
- With: adds outputs stall_cycles[31:0] and frame_cycles[31:0].
  - stall_cycles counts RUN cycles where issue is blocked.
  - frame_cycles counts cycles from LOAD through the frame_done cycle.
  - Both clear at LOAD, hold after frame_done, and reset to 0.
- Without: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. X_SIZE=4, Y_SIZE=2, NUM_CORES=1, 3-cycle core model; re_lower=0xFFC00000, im_upper=0x00300000, zoom_f=0x00002000.
   -> pixel (3,0) issues c_re=0xFFC06000; pixel (0,1) issues c_im=0x002FE000.
   -> 8 outputs with sof on first, eol on 4th and 8th, then one frame_done.
2. NUM_CORES=4, core 2 finishes before cores 0 and 1.
   -> core 2 is not acked until cores 0 and 1 retire; out_rgb stays in raster order.
3. Hold out_ready=0 for 10 cycles with results pending.
   -> out_rgb stable, no core_ack; all cores fill and issue stalls; output resumes in order with no loss.
4. Pulse start mid-frame and change zoom_f mid-frame.
   -> no restart; coordinates continue with the shadowed zoom; exactly one frame_done.
5. Assert areset at pixel 5 of 8.
   -> all outputs 0 asynchronously; a following start produces a full correct frame from (0,0).
6. With DISPATCH_PERF_EN and core_ready held low 6 cycles in RUN.
   -> stall_cycles=6; frame_cycles equals cycles from LOAD through frame_done inclusive.

Source files
------------

// File: rtl/mandelbrot_dispatch.sv
// mandelbrot_dispatch
//   Frame scheduler that walks a raster scan, computes each pixel's complex
//   coordinate incrementally, and issues pixels round-robin to NUM_CORES
//   iteration cores. Results are retired in the same round-robin order, so the
//   packer always sees a raster-ordered RGB stream.
//
//   Optional build macro: DISPATCH_PERF_EN
//     Adds stall_cycles / frame_cycles performance counters.
module mandelbrot_dispatch #(
   parameter int NUM_CORES = 4,
   parameter int X_SIZE    = 1024,
   parameter int Y_SIZE    = 768
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     start,
   input  logic [31:0]              zoom_f,
   input  logic [31:0]              re_lower,
   input  logic [31:0]              im_upper,
   output logic                     busy,
   output logic                     frame_done,
   output logic [NUM_CORES-1:0]     core_start,
   output logic [31:0]              core_c_re,
   output logic [31:0]              core_c_im,
   input  logic [NUM_CORES-1:0]     core_ready,
   input  logic [NUM_CORES-1:0]     core_done,
   input  logic [24*NUM_CORES-1:0]  core_rgb,
   output logic [NUM_CORES-1:0]     core_ack,
   output logic [23:0]              out_rgb,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sof,
   output logic                     out_eol
`ifdef DISPATCH_PERF_EN
   ,
   output logic [31:0]              stall_cycles,
   output logic [31:0]              frame_cycles
`endif
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

   localparam logic [PW-1:0] PTR_MAX = PW'(NUM_CORES - 1);
   localparam logic [XW-1:0] X_MAX   = XW'(X_SIZE - 1);
   localparam logic [YW-1:0] Y_MAX   = YW'(Y_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t state_q, state_d;

   // Frame configuration shadows, frozen at LOAD.
   logic [31:0]   zoom_q, zoom_d;
   logic [31:0]   re_base_q, re_base_d;
   logic [31:0]   im_base_q, im_base_d;

   // Issue side: raster position and incrementally computed coordinate.
   logic [31:0]   c_re_q, c_re_d;
   logic [31:0]   c_im_q, c_im_d;
   logic [XW-1:0] ix_q, ix_d;
   logic [YW-1:0] iy_q, iy_d;
   logic [PW-1:0] issue_ptr_q, issue_ptr_d;

   // Retire side: raster position of the next pixel to retire.
   logic [XW-1:0] rx_q, rx_d;
   logic [YW-1:0] ry_q, ry_d;
   logic [PW-1:0] retire_ptr_q, retire_ptr_d;

   // Output register toward the packer.
   logic [23:0]   out_rgb_q, out_rgb_d;
   logic          out_valid_q, out_valid_d;
   logic          out_sof_q, out_sof_d;
   logic          out_eol_q, out_eol_d;
   logic          out_last_q, out_last_d;

   logic          issue_go;
   logic          issue_last;
   logic          retire_go;
   logic          out_pop;
   logic          frame_end;

   // Handshake decode: which events fire this cycle.
   always_comb begin
      issue_go   = (state_q == S_RUN) && core_ready[issue_ptr_q];
      issue_last = (ix_q == X_MAX) && (iy_q == Y_MAX);
      out_pop    = out_valid_q && out_ready;
      retire_go  = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                   core_done[retire_ptr_q] && (!out_valid_q || out_ready);
      frame_end  = (state_q == S_DRAIN) && out_pop && out_last_q;
   end

   // Frame FSM next-state.
   always_comb begin
      // NOTE: next-state defaults to the current state so no latch is inferred.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  state_d = S_RUN;
         S_RUN:   if (issue_go && issue_last) state_d = S_DRAIN;
         S_DRAIN: if (frame_end) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Frame FSM state register.
   always_ff @(posedge aclk or posedge areset) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (areset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Datapath next-state: configuration load, issue stepping, retire stepping.
   always_comb begin
      zoom_d       = zoom_q;
      re_base_d    = re_base_q;
      im_base_d    = im_base_q;
      c_re_d       = c_re_q;
      c_im_d       = c_im_q;
      ix_d         = ix_q;
      iy_d         = iy_q;
      issue_ptr_d  = issue_ptr_q;
      rx_d         = rx_q;
      ry_d         = ry_q;
      retire_ptr_d = retire_ptr_q;
      out_rgb_d    = out_rgb_q;
      out_valid_d  = out_valid_q;
      out_sof_d    = out_sof_q;
      out_eol_d    = out_eol_q;
      out_last_d   = out_last_q;

      if (state_q == S_LOAD) begin
         zoom_d       = zoom_f;
         re_base_d    = re_lower;
         im_base_d    = im_upper;
         c_re_d       = re_lower;
         c_im_d       = im_upper;
         ix_d         = '0;
         iy_d         = '0;
         issue_ptr_d  = '0;
         rx_d         = '0;
         ry_d         = '0;
         retire_ptr_d = '0;
      end

      if (issue_go) begin
         if (ix_q == X_MAX) begin
            ix_d   = '0;
            iy_d   = iy_q + YW'(1);
            c_re_d = re_base_q;
            c_im_d = c_im_q - zoom_q;
         end else begin
            ix_d   = ix_q + XW'(1);
            c_re_d = c_re_q + zoom_q;
         end
         issue_ptr_d = (issue_ptr_q == PTR_MAX) ? '0 : issue_ptr_q + PW'(1);
      end

      if (retire_go) begin
         out_rgb_d   = core_rgb[int'(retire_ptr_q) * 24 +: 24];
         out_valid_d = 1'b1;
         out_sof_d   = (rx_q == '0) && (ry_q == '0);
         out_eol_d   = (rx_q == X_MAX);
         out_last_d  = (rx_q == X_MAX) && (ry_q == Y_MAX);
         if (rx_q == X_MAX) begin
            rx_d = '0;
            ry_d = ry_q + YW'(1);
         end else begin
            rx_d = rx_q + XW'(1);
         end
         retire_ptr_d = (retire_ptr_q == PTR_MAX) ? '0 : retire_ptr_q + PW'(1);
      end else if (out_pop) begin
         out_valid_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         zoom_q       <= '0;
         re_base_q    <= '0;
         im_base_q    <= '0;
         c_re_q       <= '0;
         c_im_q       <= '0;
         ix_q         <= '0;
         iy_q         <= '0;
         issue_ptr_q  <= '0;
         rx_q         <= '0;
         ry_q         <= '0;
         retire_ptr_q <= '0;
         out_rgb_q    <= '0;
         out_valid_q  <= 1'b0;
         out_sof_q    <= 1'b0;
         out_eol_q    <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         zoom_q       <= zoom_d;
         re_base_q    <= re_base_d;
         im_base_q    <= im_base_d;
         c_re_q       <= c_re_d;
         c_im_q       <= c_im_d;
         ix_q         <= ix_d;
         iy_q         <= iy_d;
         issue_ptr_q  <= issue_ptr_d;
         rx_q         <= rx_d;
         ry_q         <= ry_d;
         retire_ptr_q <= retire_ptr_d;
         out_rgb_q    <= out_rgb_d;
         out_valid_q  <= out_valid_d;
         out_sof_q    <= out_sof_d;
         out_eol_q    <= out_eol_d;
         out_last_q   <= out_last_d;
      end
   end

   // One-hot issue and ack pulses; both follow the core handshake in the same cycle.
   always_comb begin
      core_start               = '0;
      core_ack                 = '0;
      core_start[issue_ptr_q]  = issue_go;
      core_ack[retire_ptr_q]   = retire_go;
   end

   assign busy       = (state_q != S_IDLE);
   assign frame_done = frame_end;
   assign core_c_re  = c_re_q;
   assign core_c_im  = c_im_q;
   assign out_rgb    = out_rgb_q;
   assign out_valid  = out_valid_q;
   assign out_sof    = out_sof_q;
   assign out_eol    = out_eol_q;

`ifdef DISPATCH_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] fcyc_q, fcyc_d;

   // Performance counters: clear at LOAD (LOAD itself counts as frame cycle 1), hold in IDLE.
   always_comb begin
      stall_d = stall_q;
      fcyc_d  = fcyc_q;
      case (state_q)
         S_LOAD: begin
            stall_d = '0;
            fcyc_d  = 32'd1;
         end
         S_RUN: begin
            fcyc_d = fcyc_q + 32'd1;
            if (!core_ready[issue_ptr_q]) stall_d = stall_q + 32'd1;
         end
         S_DRAIN: fcyc_d = fcyc_q + 32'd1;
         default: ;
      endcase
   end

   // Performance counter registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         stall_q <= '0;
         fcyc_q  <= '0;
      end else begin
         stall_q <= stall_d;
         fcyc_q  <= fcyc_d;
      end
   end

   assign stall_cycles = stall_q;
   assign frame_cycles = fcyc_q;
`endif

endmodule

// File: tb/tb_mandelbrot_dispatch.sv
// tb_mandelbrot_dispatch
//   Directed bench: 4 cores, 4x2 frame. A frame-config table drives full
//   frames; hand sequences cover back-pressure, mid-frame start/zoom change,
//   mid-frame reset and (with DISPATCH_PERF_EN) the performance counters.
module tb_mandelbrot_dispatch;

   localparam int NC = 4;
   localparam int XS = 4;
   localparam int YS = 2;
   localparam int NPIX = XS * YS;

   logic            aclk = 1'b0;
   logic            areset;
   logic            start;
   logic [31:0]     zoom_f, re_lower, im_upper;
   logic            busy, frame_done;
   logic [NC-1:0]   core_start, core_ready, core_done, core_ack;
   logic [31:0]     core_c_re, core_c_im;
   logic [24*NC-1:0] core_rgb;
   logic [23:0]     out_rgb;
   logic            out_valid, out_ready, out_sof, out_eol;
`ifdef DISPATCH_PERF_EN
   logic [31:0]     stall_cycles, frame_cycles;
`endif

   mandelbrot_dispatch #(.NUM_CORES(NC), .X_SIZE(XS), .Y_SIZE(YS)) u_dut (
      .aclk(aclk), .areset(areset), .start(start), .zoom_f(zoom_f),
      .re_lower(re_lower), .im_upper(im_upper), .busy(busy),
      .frame_done(frame_done), .core_start(core_start), .core_c_re(core_c_re),
      .core_c_im(core_c_im), .core_ready(core_ready), .core_done(core_done),
      .core_rgb(core_rgb), .core_ack(core_ack), .out_rgb(out_rgb),
      .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
      .out_eol(out_eol)
`ifdef DISPATCH_PERF_EN
      , .stall_cycles(stall_cycles), .frame_cycles(frame_cycles)
`endif
   );

   always #5 aclk = ~aclk;

   // Result a core produces for a coordinate; the bench recomputes it from x/y.
   function automatic logic [23:0] rgb_of(input logic [31:0] re, input logic [31:0] im);
      return re[23:0] ^ {im[11:0], im[23:12]};
   endfunction

   // ---------------- core models ----------------
   int            lat [NC];
   logic [NC-1:0] m_busy, m_done, block;
   int            m_cnt [NC];
   logic [31:0]   m_re [NC];
   logic [31:0]   m_im [NC];

   always @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_busy <= '0;
         m_done <= '0;
         for (int k = 0; k < NC; k++) begin
            m_cnt[k] <= 0; m_re[k] <= '0; m_im[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NC; k++) begin
            if (core_start[k]) begin
               m_busy[k] <= 1'b1;
               m_cnt[k]  <= lat[k] - 1;
               m_re[k]   <= core_c_re;
               m_im[k]   <= core_c_im;
            end else if (m_busy[k]) begin
               if (m_cnt[k] == 0) begin
                  m_busy[k] <= 1'b0;
                  m_done[k] <= 1'b1;
               end else begin
                  m_cnt[k] <= m_cnt[k] - 1;
               end
            end
            if (core_ack[k]) m_done[k] <= 1'b0;
         end
      end
   end

   always_comb begin
      core_rgb = '0;
      for (int k = 0; k < NC; k++) core_rgb[24*k +: 24] = rgb_of(m_re[k], m_im[k]);
   end
   assign core_ready = ~(m_busy | m_done) & ~block;
   assign core_done  = m_done;

   // ---------------- monitor ----------------
   logic [31:0] iss_re [$];
   logic [31:0] iss_im [$];
   int          ack_q  [$];
   logic [25:0] out_q  [$];
   int          fd_cnt = 0;
   int          busy_cnt = 0;

   always @(posedge aclk) begin
      if (!areset) begin
         for (int k = 0; k < NC; k++) begin
            if (core_start[k]) begin
               iss_re.push_back(core_c_re);
               iss_im.push_back(core_c_im);
            end
            if (core_ack[k]) ack_q.push_back(k);
         end
         if (out_valid && out_ready) out_q.push_back({out_sof, out_eol, out_rgb});
         if (frame_done) fd_cnt++;
         if (busy) busy_cnt++;
      end
   end

   // ---------------- checking ----------------
   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [31:0] re, im, zoom;
      int          l0, l1, l2, l3;
      logic [31:0] p3_re;   // hand-computed c_re of pixel (3,0)
      logic [31:0] p4_im;   // hand-computed c_im of pixel (0,1)
   } cfg_t;

   cfg_t cfgs [3];

   task automatic clear_logs();
      iss_re.delete(); iss_im.delete(); ack_q.delete(); out_q.delete();
      busy_cnt = 0;
   endtask

   task automatic set_cfg(input int ci);
      re_lower = cfgs[ci].re;
      im_upper = cfgs[ci].im;
      zoom_f   = cfgs[ci].zoom;
      lat[0] = cfgs[ci].l0; lat[1] = cfgs[ci].l1;
      lat[2] = cfgs[ci].l2; lat[3] = cfgs[ci].l3;
   endtask

   task automatic wait_frame(input int fd0);
      for (int c = 0; c < 400 && fd_cnt == fd0; c++) @(negedge aclk);
      repeat (6) @(negedge aclk);
   endtask

   task automatic compare_frame(input int ci, input int fd0, input string tag);
      logic [31:0] er, ei;
      logic [25:0] eo;
      int x, y;
      check({tag, " frame_done count"}, 64'(fd_cnt - fd0), 64'd1);
      check({tag, " issue count"}, 64'(iss_re.size()), 64'(NPIX));
      check({tag, " output count"}, 64'(out_q.size()), 64'(NPIX));
      check({tag, " c_re pixel(3,0)"}, (iss_re.size() > 3) ? 64'(iss_re[3]) : 64'hDEAD, 64'(cfgs[ci].p3_re));
      check({tag, " c_im pixel(0,1)"}, (iss_im.size() > 4) ? 64'(iss_im[4]) : 64'hDEAD, 64'(cfgs[ci].p4_im));
      for (int i = 0; i < NPIX; i++) begin
         x  = i % XS;
         y  = i / XS;
         er = cfgs[ci].re + 32'(x) * cfgs[ci].zoom;
         ei = cfgs[ci].im - 32'(y) * cfgs[ci].zoom;
         eo = {(i == 0), (x == XS - 1), rgb_of(er, ei)};
         check($sformatf("%s issue coord %0d", tag, i),
               (i < iss_re.size()) ? {iss_re[i], iss_im[i]} : 64'hDEAD, {er, ei});
         check($sformatf("%s out sof/eol/rgb %0d", tag, i),
               (i < out_q.size()) ? 64'(out_q[i]) : 64'hDEAD, 64'(eo));
         check($sformatf("%s ack order %0d", tag, i),
               (i < ack_q.size()) ? 64'(ack_q[i]) : 64'hDEAD, 64'(i % NC));
      end
      check({tag, " busy after frame"}, 64'(busy), 64'd0);
   endtask

   // mode 0: plain frame; 1: start pulse + config change mid-frame; 2: 6-cycle ready block in RUN
   task automatic run_frame(input int ci, input int mode, input string tag);
      int fd0;
      clear_logs();
      fd0 = fd_cnt;
      @(negedge aclk);
      set_cfg(ci);
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      check({tag, " busy in LOAD"}, 64'(busy), 64'd1);
      if (mode == 1) begin
         repeat (5) @(negedge aclk);
         start    = 1'b1;
         zoom_f   = 32'h00AB_CDEF;
         re_lower = 32'h1234_5678;
         im_upper = 32'h0F0F_0F0F;
         @(negedge aclk);
         start = 1'b0;
      end
      if (mode == 2) begin
         repeat (3) @(negedge aclk);
         block = '1;
         repeat (6) @(negedge aclk);
         block = '0;
      end
      wait_frame(fd0);
      compare_frame(ci, fd0, tag);
`ifdef DISPATCH_PERF_EN
      if (mode == 2) begin
         check({tag, " stall_cycles"}, 64'(stall_cycles), 64'd6);
         check({tag, " frame_cycles"}, 64'(frame_cycles), 64'(busy_cnt));
      end
`endif
   endtask

   initial begin
      int fd0;
      int bad;
      logic [23:0] rgb0;

      cfgs[0] = '{re: 32'hFFC0_0000, im: 32'h0030_0000, zoom: 32'h0000_2000,
                  l0: 3, l1: 3, l2: 3, l3: 3, p3_re: 32'hFFC0_6000, p4_im: 32'h002F_E000};
      cfgs[1] = '{re: 32'h7FFF_FFF0, im: 32'h8000_0004, zoom: 32'h0000_0010,
                  l0: 5, l1: 4, l2: 1, l3: 2, p3_re: 32'h8000_0020, p4_im: 32'h7FFF_FFF4};
      cfgs[2] = '{re: 32'h0000_0000, im: 32'h0000_0000, zoom: 32'hFFFF_FFFF,
                  l0: 1, l1: 1, l2: 1, l3: 1, p3_re: 32'hFFFF_FFFD, p4_im: 32'h0000_0001};

      areset = 1'b1; start = 1'b0; out_ready = 1'b1; block = '0;
      zoom_f = '0; re_lower = '0; im_upper = '0;
      for (int k = 0; k < NC; k++) lat[k] = 1;
      repeat (2) @(negedge aclk);
      check("reset ctrl outputs",
            64'({busy, frame_done, out_valid, out_sof, out_eol, core_start, core_ack, out_rgb}), 64'd0);
      check("reset coord outputs", {core_c_re, core_c_im}, 64'd0);
      areset = 1'b0;
      @(negedge aclk);
      check("idle busy", 64'(busy), 64'd0);

      // Table-driven full frames (cfg 1 has core 2 finishing ahead of cores 0 and 1).
      for (int ci = 0; ci < 3; ci++) run_frame(ci, 0, $sformatf("cfg%0d", ci));

      // start pulse and configuration change mid-frame are ignored.
      run_frame(0, 1, "midstart");

      // Back-pressure: out_ready low for 10 cycles with results pending.
      clear_logs();
      fd0 = fd_cnt;
      @(negedge aclk);
      set_cfg(2);
      out_ready = 1'b0;
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      for (int c = 0; c < 50 && !out_valid; c++) @(negedge aclk);
      check("hold first out_valid", 64'(out_valid), 64'd1);
      rgb0 = out_rgb;
      check("hold first rgb", 64'(rgb0), 64'(rgb_of(32'h0, 32'h0)));
      bad = 0;
      repeat (10) begin
         @(negedge aclk);
         if (out_rgb !== rgb0 || core_ack !== '0 || out_valid !== 1'b1) bad++;
      end
      check("hold stable, no ack", 64'(bad), 64'd0);
      check("hold all cores done", 64'(core_done), 64'hF);
      check("hold issue stalled", 64'(core_start), 64'd0);
      out_ready = 1'b1;
      wait_frame(fd0);
      compare_frame(2, fd0, "hold");

      // Asynchronous reset after 5 of 8 pixels, then a clean frame.
      clear_logs();
      @(negedge aclk);
      set_cfg(0);
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      for (int c = 0; c < 400 && out_q.size() < 5; c++) @(negedge aclk);
      check("abort reached pixel 5", 64'(out_q.size() >= 5), 64'd1);
      fd0 = fd_cnt;
      #2 areset = 1'b1;
      #1;
      check("abort ctrl outputs",
            64'({busy, frame_done, out_valid, out_sof, out_eol, core_start, core_ack, out_rgb}), 64'd0);
      check("abort coord outputs", {core_c_re, core_c_im}, 64'd0);
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      check("abort no frame_done", 64'(fd_cnt - fd0), 64'd0);
      run_frame(0, 0, "after_reset");

      // Forced 6-cycle issue stall in RUN.
      run_frame(2, 2, "stall");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
